// File: rtl/mod_addsub_ctrl_if.sv
// Request/response bundle of the modular add/sub unit.
// start/subtract/in_a/in_b/in_m go in; result/done/busy come back.
interface mod_addsub_ctrl_if #(
  parameter int N = 1027
);
  logic         start;
  logic         subtract;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;
  logic         busy;

  modport master (
    output start, subtract, in_a, in_b, in_m,
    input  result, done, busy
  );

  modport slave (
    input  start, subtract, in_a, in_b, in_m,
    output result, done, busy
  );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Modular add/sub: two adder passes, then pick the reduced value.
// Ports: clk, resetn (async, active-high), bus (slave side).
module mod_addsub_ctrl #(
  parameter int N = 1027
) (
  input  logic              clk,
  input  logic              resetn,
  mod_addsub_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    P1W,
    P2,
    P2W
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] m_q;
  logic         op_q;
  logic [N:0]   s1_q;
  logic [N-1:0] res_q;
  logic         done_q;

  logic         add_start;
  logic         add_sub;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic [N:0]   add_res;
  logic         add_done;
  logic [N-1:0] sel;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    add_start = 1'b0;
    add_sub   = op_q;
    add_a     = a_q;
    add_b     = b_q;
    unique case (state)
      IDLE: if (bus.start) state_nx = P1;
      P1: begin
        add_start = 1'b1;
        state_nx  = P1W;
      end
      P1W: state_nx = P2;
      P2: begin
        add_start = 1'b1;
        add_sub   = ~op_q;
        add_a     = s1_q[N-1:0];
        add_b     = m_q;
        state_nx  = P2W;
      end
      P2W: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bit N of each pass: carry for add, borrow for sub.
  // A set S1 carry means the sum exceeds M, so the
  // corrected pass is always right; otherwise a clean
  // add-correction (no borrow) or a sub borrow picks S2.
  always_comb begin
    sel = s1_q[N-1:0];
    if (s1_q[N])
      sel = add_res[N-1:0];
    else if (!op_q && !add_res[N])
      sel = add_res[N-1:0];
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      op_q   <= 1'b0;
      s1_q   <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        a_q  <= bus.in_a;
        b_q  <= bus.in_b;
        m_q  <= bus.in_m;
        op_q <= bus.subtract;
      end
      if (state == P1W) s1_q <= add_res;
      if (state == P2W) res_q <= sel;
      done_q <= (state == P2W);
    end
  end

  // One-cycle adder stage; carries no reset, control is
  // driven purely by the FSM.
  always_ff @(posedge clk) begin
    add_done <= add_start;
    if (add_start) begin
      if (add_sub)
        add_res <= {1'b0, add_a} - {1'b0, add_b};
      else
        add_res <= {1'b0, add_a} + {1'b0, add_b};
    end
  end

  assign bus.result = res_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state != IDLE);

  a_adder_done: assert property (
    @(posedge clk) disable iff (resetn)
    (state == P1W || state == P2W) |-> add_done
  );

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl.
// Drives on negedge side, samples mid-cycle.
module tb_mod_addsub_ctrl;
  localparam int N = 1027;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  mod_addsub_ctrl_if #(.N(N)) bus ();

  mod_addsub_ctrl #(.N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic sub,
                        input logic [N-1:0] a,
                        input logic [N-1:0] b,
                        input logic [N-1:0] m);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.subtract = sub;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_m     = m;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in_a  = '1;
    bus.in_b  = '1;
  endtask

  task automatic test_reset;
    resetn    = 1'b1;
    bus.start = 1'b0;
    bus.subtract = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.in_m  = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got %b exp 0", bus.done);
    end
    n_checks++;
    if (bus.result !== '0) begin
      n_fail++;
      $display("FAIL reset_result got %h exp 0",
               bus.result[63:0]);
    end
    resetn = 1'b0;
  endtask

  task automatic test_add_timing;
    logic [N-1:0] exp_r;
    exp_r = N'(3);
    launch(1'b0, N'(7), N'(9), N'(13));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL add_timing_t%0d busy=%b done=%b exp 1/0",
                 k, bus.busy, bus.done);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_timing_t5 done=%b busy=%b exp 1/0",
               bus.done, bus.busy);
    end
    n_checks++;
    if (bus.result !== exp_r) begin
      n_fail++;
      $display("FAIL add_7_9 got %h exp %h",
               bus.result[63:0], exp_r[63:0]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse got %b exp 0", bus.done);
    end
  endtask

  task automatic test_vectors;
    logic [N-1:0] va [7];
    logic [N-1:0] vb [7];
    logic [N-1:0] vm [7];
    logic [N-1:0] ve [7];
    logic         vs [7];
    logic [N-1:0] mx;
    mx = '1;
    vs[0] = 1; va[0] = N'(3); vb[0] = N'(9); vm[0] = N'(13); ve[0] = N'(7);
    vs[1] = 1; va[1] = N'(9); vb[1] = N'(3); vm[1] = N'(13); ve[1] = N'(6);
    vs[2] = 1; va[2] = N'(5); vb[2] = N'(5); vm[2] = N'(13); ve[2] = N'(0);
    vs[3] = 0; va[3] = N'(6); vb[3] = N'(7); vm[3] = N'(13); ve[3] = N'(0);
    vs[4] = 0; va[4] = N'(2); vb[4] = N'(3); vm[4] = N'(13); ve[4] = N'(5);
    vs[5] = 0; va[5] = mx - 1; vb[5] = mx - 1; vm[5] = mx; ve[5] = mx - 2;
    vs[6] = 0; va[6] = mx - 1; vb[6] = '0;     vm[6] = mx; ve[6] = mx - 1;
    for (int i = 0; i < 7; i++) begin
      launch(vs[i], va[i], vb[i], vm[i]);
      repeat (5) @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL vec%0d_done got %b exp 1", i, bus.done);
      end
      n_checks++;
      if (bus.result !== ve[i]) begin
        n_fail++;
        $display("FAIL vec%0d_result got %h exp %h (low 64b)",
                 i, bus.result[63:0], ve[i][63:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] r1;
    logic [N-1:0] r2;
    r1 = N'(9);
    r2 = N'(7);
    launch(1'b0, N'(4), N'(5), N'(13));
    @(negedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.subtract = 1'b0;
    bus.in_a     = N'(1);
    bus.in_b     = N'(1);
    bus.in_m     = N'(13);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.result !== r1) begin
      n_fail++;
      $display("FAIL b2b_first done=%b res=%h exp 1/%h",
               bus.done, bus.result[63:0], r1[63:0]);
    end
    bus.start    = 1'b1;
    bus.subtract = 1'b1;
    bus.in_a     = N'(2);
    bus.in_b     = N'(8);
    bus.in_m     = N'(13);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.result !== r1) begin
        n_fail++;
        $display("FAIL b2b_hold_t%0d done=%b res=%h exp 0/%h",
                 k, bus.done, bus.result[63:0], r1[63:0]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.result !== r2) begin
      n_fail++;
      $display("FAIL b2b_second done=%b res=%h exp 1/%h",
               bus.done, bus.result[63:0], r2[63:0]);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [N-1:0] r;
    r = N'(6);
    launch(1'b0, N'(7), N'(9), N'(13));
    repeat (3) @(negedge clk);
    #1;
    resetn = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid busy=%b done=%b exp 0/0",
               bus.busy, bus.done);
    end
    n_checks++;
    if (bus.result !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_result got %h exp 0",
               bus.result[63:0]);
    end
    @(negedge clk);
    resetn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_spurious_%0d done=%b busy=%b exp 0/0",
                 k, bus.done, bus.busy);
      end
    end
    launch(1'b1, N'(9), N'(3), N'(13));
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.result !== r) begin
      n_fail++;
      $display("FAIL rst_fresh done=%b res=%h exp 1/%h",
               bus.done, bus.result[63:0], r[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_vectors();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_addsub_ctrl.md
Name: mod_addsub_ctrl

Overview:
- Sequencing stage that wraps the pipelined 1027-bit carry-select adder/subtractor (mpadder3) and turns it into a modular add/subtract unit.
- Computes (A + B) mod M or (A − B) mod M by issuing two adder passes and selecting the reduced result.
- Sits between the Montgomery multiplier top-level control and the adder. It drives the adder's start/subtract/in_a/in_b and consumes its result/done.

Parameters:
- N, 1027, operand/modulus width; must equal the adder operand width (adder result is N+1 bits).

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  one clock; reset is asynchronous and active-high (asserted = 1, acts immediately, independent of clk)
- start  input  1  single-cycle request; sampled only in IDLE
- subtract  input  1  0: A+B mod M, 1: A−B mod M
- in_a  input  N  operand A, precondition A < M
- in_b  input  N  operand B, precondition B < M
- in_m  input  N  modulus M, M > 0
- result  output  N  reduced result, held stable until next accepted start
- done  output  1  one-cycle pulse, result valid in that cycle and after
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset: state=IDLE, result=0, done=0, busy=0, operand/intermediate registers=0. The adder itself has no reset; its done output is never used for control. Timing is purely state-driven.
- Capture: in IDLE with start=1 at edge t, latch in_a, in_b, in_m, subtract. busy=1 from t+1. start while busy is ignored. Inputs may change after t.
- States: IDLE → P1 → P1W → P2 → P2W → IDLE.
- P1 (cycle t+1): adder start=1, adder in_a=A, in_b=B, subtract=op.
- P1W (t+2): adder result valid. Register S1 = adder result (N+1 bits).
- P2 (t+3): adder start=1, in_a=S1[N−1:0], in_b=M, subtract=~op.
- P2W (t+4): adder result S2 valid. Select:
  - add, S1[N]=1 → result=S2[N−1:0] (sum ≥ 2^N > M; wrap of the low bits is exact).
  - add, S1[N]=0, S2[N]=0 (no borrow) → result=S2[N−1:0].
  - add, S1[N]=0, S2[N]=1 (borrow) → result=S1[N−1:0].
  - sub, S1[N]=1 (A<B, borrow) → result=S2[N−1:0] (D+M, low N bits).
  - sub, S1[N]=0 → result=S1[N−1:0].
- result is registered at edge ending P2W. done=1 and busy=0 in cycle t+5; state returns to IDLE.
- Fixed latency: done 5 cycles after the accepting edge, regardless of data. No early exit.
- A start in the same cycle done is high is accepted (state is IDLE). The next done follows 5 cycles later. result holds the old value until it is overwritten.
- Adder result bit N is interpreted as: add → carry out; sub → borrow (1 = in_a < in_b).
- Reset mid-operation: abort immediately, all outputs return to reset values. No done is produced for the aborted request.
- Precondition violations (A≥M or B≥M) give an unspecified result but correct timing. The bench does not check the value.
- Assertion (verification only): in P1W and P2W, the adder done equals 1.

Test Plan:
- M=13, A=7, B=9, subtract=0 → done at t+5, result=3; busy high t+1..t+4.
- M=13, A=3, B=9, subtract=1 → result=7 (borrow path, D+M). M=13, A=9, B=3, subtract=1 → result=6.
- M=13, A=5, B=5, subtract=1 → result=0. M=13, A=6, B=7, add → result=0 (S2 exactly zero, no borrow).
- M=2^1027−1, A=B=2^1027−2, add → S1[1026+1]=1 path, result=2^1027−3. Also A=2^1027−2, B=0, add → result=2^1027−2 (borrow path keeps S1).
- Start pulses at t+2 and t+3 while busy are ignored. A new start in the done cycle (t+5) is accepted → second done at t+10 with correct value; result holds first value t+5..t+9.
- Assert resetn=1 asynchronously mid-P2 → busy, done and result go to 0 before the next edge. After release, no spurious done; a fresh start completes normally.
